// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// Module  : main_fsm
// Brief   : Multicycle RV32I main control FSM (Moore, memory-ready stall,
//           sticky illegal-instruction trap).
// Revision: 1.0 - initial release
// ============================================================================
module main_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= state_t'(RESET_STATE);
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECR;
                    c_OP_I:           w_next = S_EXECI;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_BEQ:         w_next = S_BEQ;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            // Encodings 12..15 can only appear through an upset; park in trap.
            default:    w_next = S_TRAP;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            default: ;
        endcase
        // Reset gates write enables immediately, even before the state register settles.
        if (!reset_n) begin
            IRWrite  = 1'b0;
            PCUpdate = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_main_fsm
// Brief   : Directed self-checking bench for main_fsm.
// Revision: 1.0 - initial release
// ============================================================================
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b1;
    logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    main_fsm #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp);
        chk(tag, {4'd0, state}, {4'd0, exp});
    endtask

    initial begin
        // Reset held with memory ready
        reset_n = 1'b0; mem_ready = 1'b1; op = 7'd0;
        tick(); tick();
        chk_st("rst_state", 4'd0);
        chk("rst_irw", {7'd0, IRWrite}, 8'd0);
        chk("rst_pcu", {7'd0, PCUpdate}, 8'd0);
        chk("rst_rw", {7'd0, RegWrite}, 8'd0);
        chk("rst_mw", {7'd0, MemWrite}, 8'd0);
        chk("rst_ill", {7'd0, illegal}, 8'd0);

        // Release: fetch can complete on the first edge
        reset_n = 1'b1; op = 7'b0000011;
        #1;
        chk("rel_irw", {7'd0, IRWrite}, 8'd1);
        chk("rel_pcu", {7'd0, PCUpdate}, 8'd1);
        chk("f_srcb", {6'd0, ALUSrcB}, 8'd2);
        chk("f_res", {6'd0, ResultSrc}, 8'd2);

        // lw: 0,1,2,3,4,0 with one wait cycle in S3
        tick(); chk_st("lw_s1", 4'd1);
        chk("lw_dec_srca", {6'd0, ALUSrcA}, 8'd1);
        tick(); chk_st("lw_s2", 4'd2);
        chk("lw_adr_srca", {6'd0, ALUSrcA}, 8'd2);
        mem_ready = 1'b0;
        tick(); chk_st("lw_s3", 4'd3);
        chk("lw_s3_adr", {7'd0, AdrSrc}, 8'd1);
        chk("lw_s3_rw", {7'd0, RegWrite}, 8'd0);
        tick(); chk_st("lw_s3_hold", 4'd3);
        mem_ready = 1'b1;
        tick(); chk_st("lw_s4", 4'd4);
        chk("lw_s4_rw", {7'd0, RegWrite}, 8'd1);
        chk("lw_s4_res", {6'd0, ResultSrc}, 8'd1);
        tick(); chk_st("lw_s0", 4'd0);

        // Fetch stall
        mem_ready = 1'b0; op = 7'b0110011;
        #1;
        chk("fst_irw", {7'd0, IRWrite}, 8'd0);
        tick(); chk_st("fst_hold", 4'd0);
        mem_ready = 1'b1;

        // R-type
        tick(); chk_st("r_s1", 4'd1);
        tick(); chk_st("r_s6", 4'd6);
        chk("r_aluop", {6'd0, ALUOp}, 8'd2);
        chk("r_srca", {6'd0, ALUSrcA}, 8'd2);
        tick(); chk_st("r_s7", 4'd7);
        chk("r_rw", {7'd0, RegWrite}, 8'd1);
        tick(); chk_st("r_s0", 4'd0);

        // I-type
        op = 7'b0010011;
        tick(); chk_st("i_s1", 4'd1);
        tick(); chk_st("i_s8", 4'd8);
        chk("i_srcb", {6'd0, ALUSrcB}, 8'd1);
        chk("i_aluop", {6'd0, ALUOp}, 8'd2);
        tick(); chk_st("i_s7", 4'd7);
        tick(); chk_st("i_s0", 4'd0);

        // sw with 3 stall cycles in S5
        op = 7'b0100011;
        tick(); chk_st("sw_s1", 4'd1);
        tick(); chk_st("sw_s2", 4'd2);
        tick();
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            #1;
            chk_st("sw_s5_wait", 4'd5);
            chk("sw_mw_wait", {7'd0, MemWrite}, 8'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_st("sw_s5_last", 4'd5);
        chk("sw_mw_last", {7'd0, MemWrite}, 8'd1);
        tick(); chk_st("sw_s0", 4'd0);
        chk("sw_mw_off", {7'd0, MemWrite}, 8'd0);

        // beq
        op = 7'b1100011;
        tick(); chk_st("beq_s1", 4'd1);
        tick(); chk_st("beq_s10", 4'd10);
        chk("beq_br", {7'd0, Branch}, 8'd1);
        chk("beq_aluop", {6'd0, ALUOp}, 8'd1);
        tick(); chk_st("beq_s0", 4'd0);

        // jal
        op = 7'b1101111;
        tick(); chk_st("jal_s1", 4'd1);
        tick(); chk_st("jal_s9", 4'd9);
        chk("jal_pcu", {7'd0, PCUpdate}, 8'd1);
        chk("jal_srcb", {6'd0, ALUSrcB}, 8'd2);
        tick(); chk_st("jal_s7", 4'd7);
        tick(); chk_st("jal_s0", 4'd0);

        // Asynchronous reset in the middle of a store
        op = 7'b0100011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("mid_mw", {7'd0, MemWrite}, 8'd1);
        reset_n = 1'b0;
        #1;
        chk_st("mid_rst_state", 4'd0);
        chk("mid_rst_mw", {7'd0, MemWrite}, 8'd0);
        mem_ready = 1'b1;
        tick();
        reset_n = 1'b1; op = 7'b1110011;
        tick(); chk_st("ill_s1", 4'd1);

        // Illegal opcode: sticky trap
        tick(); chk_st("ill_s11", 4'd11);
        chk("ill_flag", {7'd0, illegal}, 8'd1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("ill_sticky", {3'd0, illegal, state}, {3'd0, 1'b1, 4'd11});
            chk("ill_en", {4'd0, IRWrite, PCUpdate, RegWrite, MemWrite}, 8'd0);
        end
        reset_n = 1'b0;
        #1;
        chk("ill_clr", {7'd0, illegal}, 8'd0);
        chk_st("ill_clr_state", 4'd0);
        tick();
        reset_n = 1'b1;
        tick(); chk_st("post_rst_fetch", 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/main_fsm.md
# main_fsm

Multicycle main control FSM for the RV32I multicycle core. It decodes `op` across fetch, decode, execute, memory and writeback states. It drives the datapath mux selects, the write enables and the 2-bit `ALUOp` consumed directly by `aludecoder`. It is a Moore machine with a memory-ready stall, and it has a sticky illegal-instruction trap.

## Interface
- `RESET_STATE`, 4'd0: state entered on reset (Fetch); not to be overridden in the core.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: instr[6:0] from the instruction register (valid from Decode onward).
- `mem_ready` in 1: memory has completed the current access this cycle.
- `AdrSrc` out 1: 0 = PC, 1 = Result.
- `IRWrite` out 1: instruction register / OldPC load.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1 reg A.
- `ALUSrcB` out 2: 00 reg B, 01 ImmExt, 10 constant 4.
- `ALUOp` out 2: 00 add, 01 sub/branch, 10 funct-decoded; to `aludecoder`.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `PCUpdate` out 1: unconditional PC write.
- `Branch` out 1: downstream PCWrite = PCUpdate | (Branch & Zero).
- `RegWrite` out 1: register file write enable.
- `MemWrite` out 1: data memory write request.
- `illegal` out 1: sticky unsupported-opcode flag.
- `state` out 4: current state encoding, for debug/bench.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
- State encodings and outputs. Unlisted outputs are 0; unlisted selects are 00.
  - S0 Fetch: ALUSrcB=10, ResultSrc=10, IRWrite=PCUpdate=mem_ready.
  - S1 Decode: ALUSrcA=01, ALUSrcB=01.
  - S2 MemAdr: ALUSrcA=10, ALUSrcB=01.
  - S3 MemRead: AdrSrc=1.
  - S4 MemWB: ResultSrc=01, RegWrite=1.
  - S5 MemWrite: AdrSrc=1, MemWrite=1.
  - S6 ExecuteR: ALUSrcA=10, ALUOp=10.
  - S7 ALUWB: RegWrite=1.
  - S8 ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - S9 JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - S10 BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - S11 Trap: all enables 0, `illegal`=1.
- Transitions:
  - S0→S1 only when mem_ready, else hold S0.
  - S1 by op: lw/sw→S2, R→S6, I→S8, jal→S9, beq→S10, any other→S11.
  - S2: op=lw→S3, otherwise S5.
  - S3→S4 when mem_ready, else hold; S4→S0.
  - S5→S0 when mem_ready, else hold with MemWrite held at 1.
  - S6→S7; S8→S7; S9→S7; S7→S0; S10→S0.
  - S11 holds until reset.
- Codes 12–15 are unreachable; if entered, next state is S11.
- Outputs decode combinationally from the state register only, plus `mem_ready` in S0.

## Timing
- `reset_n` low asynchronously forces state=S0 and `illegal`=0. While reset is low, IRWrite, PCUpdate, RegWrite and MemWrite are forced 0 regardless of `mem_ready`.
- The first fetch can complete on the first rising edge after `reset_n` deasserts, provided `mem_ready`=1.
- Cycles per instruction with zero wait states:
  - lw 5 (S0 S1 S2 S3 S4)
  - sw 4
  - R 4
  - I 4
  - jal 4
  - beq 3
- Each wait cycle in S0, S3 or S5 adds one cycle.
- `ALUOp` is valid in the same cycle as the state, so `aludecoder` output is valid within that cycle. No pipelining.
- `op` is sampled only in S1 and S2. It must be stable from the IRWrite edge until the instruction returns to S0.
- Reset asserted mid-instruction (for example S5 with MemWrite=1) drops all enables immediately; the next cycle after release is Fetch.

## Test plan
- Reset: hold `reset_n`=0 with mem_ready=1 → `state`=0 and IRWrite=PCUpdate=RegWrite=MemWrite=0. Release → IRWrite=1 in S0, `state`=1 on the next edge.
- lw, mem_ready=1: op=0000011 → `state` sequence 0,1,2,3,4,0. RegWrite=1 only in S4, ResultSrc=01 there.
- R-type then I-type: op=0110011 → 0,1,6,7,0 with ALUOp=10 in S6. op=0010011 → 0,1,8,7,0 with ALUSrcB=01 in S8.
- sw with stall: op=0100011, mem_ready low 3 cycles in S5 → MemWrite=1 for 4 consecutive cycles, then `state`=0.
- beq / jal:
  - op=1100011 → 0,1,10,0 with Branch=1 and ALUOp=01 in S10.
  - op=1101111 → 0,1,9,7,0 with PCUpdate=1 in S9.
- Illegal: op=1110011 → S1→S11, `illegal`=1 sticky over 20 cycles with no enables. Pulsing `reset_n` low clears it.
